// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I instruction-fetch path: fault codes, the fault NOP and the imem FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

    // rsp_fault encodings, listed in decode priority order after FLT_OK
    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_UNPROG   = 2'b11;

    // addi x0,x0,0 -- returned in place of the word on any faulting fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/imem_array.sv
// 1W/1R synchronous RAM, DEPTH x WIDTH, no reset; kept standalone so an SRAM macro can drop in.
// Latency: read data valid the cycle after rd_en; write lands at the clock edge.
// Backpressure: none; rd_data holds its value while rd_en is low.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read port; rd_data registered output.
module imem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately not reset so it maps onto a plain SRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_sync.sv
// Loadable synchronous instruction memory: program image written in LOAD, fetches served in RUN.
// Latency: 1 cycle from request accept to rsp_valid; back-to-back accepts give one response per cycle.
// Backpressure: response held while rsp_valid & !rsp_ready; req_ready low until the held response drains.
// Ports: clk/rst_n; prog_* load port with loading status; req_* fetch request; rsp_* fetch response with fault code.
module instr_mem_sync
    import rv32i_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter int                DEPTH     = 64,
    parameter int                ADDR_W    = 32,
    parameter logic [WIDTH-1:0]  NOP_INSTR = rv32i_pkg::NOP_INSTR,
    localparam int               AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_start,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [WIDTH-1:0]  prog_data,
    input  logic              prog_done,
    output logic              loading,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_instr,
    output logic [1:0]        rsp_fault,
    input  logic              rsp_ready
);

    state_e           state_q,     state_d;
    logic             pending_q,   pending_d;
    logic             hwm_valid_q, hwm_valid_d;
    logic [AW-1:0]    hwm_q,       hwm_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_fault_q, rsp_fault_d;
    // Set when the captured fetch was clean, selecting RAM data over the NOP.
    logic             data_ok_q,   data_ok_d;

    logic             no_inflight;
    logic             accept;
    logic             wr_en;
    logic [1:0]       flt;
    logic [AW-1:0]    idx_lo;
    logic [WIDTH-1:0] rd_data;

    // Low word-index bits address the RAM; everything above them must be zero
    // for the fetch to be in range (no aliasing onto lower words).
    assign idx_lo = req_addr[AW+1:2];

    always_comb begin
        flt = FLT_OK;
        if (req_addr[1:0] != 2'b00) begin
            flt = FLT_MISALIGN;
        end else if (req_addr[ADDR_W-1:AW+2] != '0) begin
            flt = FLT_RANGE;
        end else if (!hwm_valid_q || (idx_lo > hwm_q)) begin
            flt = FLT_UNPROG;
        end
    end

    assign no_inflight = !rsp_valid_q || rsp_ready;
    assign req_ready   = (state_q == RUN) && !pending_q && no_inflight;
    assign accept      = req_valid && req_ready;
    assign wr_en       = (state_q == LOAD) && prog_we;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hwm_valid_d = hwm_valid_q;
        hwm_d       = hwm_q;
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        data_ok_d   = data_ok_q;

        case (state_q)
            LOAD: begin
                if (wr_en && (!hwm_valid_q || (prog_addr > hwm_q))) begin
                    hwm_d       = prog_addr;
                    hwm_valid_d = 1'b1;
                end
                if (prog_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A reload request waits for the current response to be consumed
                // so the consumer never loses a fetched word.
                if (prog_start || pending_q) begin
                    if (no_inflight) begin
                        state_d     = LOAD;
                        pending_d   = 1'b0;
                        hwm_valid_d = 1'b0;
                    end else begin
                        pending_d   = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Capture is aligned with the RAM read issued on the same accept edge.
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = flt;
            data_ok_d   = (flt == FLT_OK);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            pending_q   <= 1'b0;
            hwm_valid_q <= 1'b0;
            hwm_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= FLT_OK;
            data_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            hwm_valid_q <= hwm_valid_d;
            hwm_q       <= hwm_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            data_ok_q   <= data_ok_d;
        end
    end

    imem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (accept),
        .rd_addr (idx_lo),
        .rd_data (rd_data)
    );

    assign loading   = (state_q == LOAD);
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_instr = data_ok_q ? rd_data : NOP_INSTR;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed bench for instr_mem_sync with a response scoreboard.
// Latency: n/a.
// Backpressure: exercised via rsp_ready stalls.
module tb_instr_mem_sync;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  flt;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        prog_start;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        prog_done;
    logic        loading;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic [1:0]  rsp_fault;
    logic        rsp_ready;

    int total = 0;
    int bad   = 0;
    exp_t sbq[$];

    logic [31:0] prog [21] = '{
        32'h00500113, 32'h00C00193, 32'hFF718393, 32'h0023E233, 32'h0041F2B3,
        32'h004282B3, 32'h02728863, 32'h0041A233, 32'h00020463, 32'h00000293,
        32'h0023A233, 32'h005203B3, 32'h402383B3, 32'h0471AA23, 32'h06002103,
        32'h005104B3, 32'h008001EF, 32'h00100113, 32'h00910133, 32'h0221A023,
        32'h00210063
    };

    instr_mem_sync dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prog_start (prog_start),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_done  (prog_done),
        .loading    (loading),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_instr  (rsp_instr),
        .rsp_fault  (rsp_fault),
        .rsp_ready  (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every consumed response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rsp_instr", rsp_instr, e.instr);
                chk("rsp_fault", {30'd0, rsp_fault}, {30'd0, e.flt});
            end
        end
    end

    task automatic load_prog();
        for (int i = 0; i < 21; i++) begin
            prog_we   = 1'b1;
            prog_addr = 6'(i);
            prog_data = prog[i];
            tick();
        end
        prog_we   = 1'b0;
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        chk("loading_after_done", {31'd0, loading}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        sbq.push_back('{instr: ei, flt: ef});
        tick();
        req_valid = 1'b0;
        chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        prog_start = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        prog_done  = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_loading",   {31'd0, loading},   32'd1);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_instr", rsp_instr, NOP);
        chk("rst_rsp_fault", {30'd0, rsp_fault}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: load and back-to-back fetches
        load_prog();
        fetch(32'h00, 32'h00500113, 2'b00);
        fetch(32'h04, 32'h00C00193, 2'b00);
        fetch(32'h50, 32'h00210063, 2'b00);
        tick();
        chk("t1_drained", sbq.size(), 32'd0);
        chk("t1_rsp_clear", {31'd0, rsp_valid}, 32'd0);

        // 2: fault decode
        fetch(32'h54,  NOP, 2'b11);
        fetch(32'h100, NOP, 2'b10);
        fetch(32'h102, NOP, 2'b01);
        tick();
        chk("t2_drained", sbq.size(), 32'd0);

        // 3: stalled response held stable
        rsp_ready = 1'b0;
        fetch(32'h08, 32'hFF718393, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_hold_instr", rsp_instr, 32'hFF718393);
            chk("t3_req_ready",  {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3_rsp_clear", {31'd0, rsp_valid}, 32'd0);
        chk("t3_drained", sbq.size(), 32'd0);

        // 4: prog_start deferred until the stalled response drains
        rsp_ready = 1'b0;
        fetch(32'h00, 32'h00500113, 2'b00);
        prog_start = 1'b1;
        tick();
        prog_start = 1'b0;
        chk("t4_still_run",  {31'd0, loading},   32'd0);
        chk("t4_pending_rr", {31'd0, req_ready}, 32'd0);
        tick();
        chk("t4_still_run2", {31'd0, loading},   32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("t4_loading",  {31'd0, loading},   32'd1);
        chk("t4_req_rdy",  {31'd0, req_ready}, 32'd0);
        chk("t4_drained",  sbq.size(), 32'd0);
        req_valid = 1'b1;
        req_addr  = 32'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req_valid = 1'b0;
        load_prog();

        // 5: writes ignored in RUN
        prog_we   = 1'b1;
        prog_addr = 6'd0;
        prog_data = 32'hDEADBEEF;
        tick();
        prog_we = 1'b0;
        fetch(32'h00, 32'h00500113, 2'b00);
        tick();
        chk("t5_drained", sbq.size(), 32'd0);

        // 6: asynchronous reset mid-stream
        rsp_ready = 1'b0;
        fetch(32'h04, 32'h00C00193, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("t6_loading",  {31'd0, loading},   32'd1);
        chk("t6_req_rdy",  {31'd0, req_ready}, 32'd0);
        sbq.delete();
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        prog_done = 1'b1;
        tick();
        prog_done = 1'b0;
        chk("t6_run", {31'd0, loading}, 32'd0);
        fetch(32'h00, NOP, 2'b11);
        tick();
        chk("t6_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
Parametrised, synchronous, loadable instruction memory. It is the successor to the fixed 21-entry combinational instruction ROM.
- Program image is written through a load port after reset; no hard-coded contents.
- Serves fetch requests from the RV32I core over a valid/ready request and response handshake with 1-cycle latency.
- Flags misaligned, out-of-range and unprogrammed fetches; each faulting fetch returns a NOP.

Parameters:
- WIDTH, 32, instruction/data width in bits.
- DEPTH, 64, number of instruction words; power of 2, at least 4.
- ADDR_W, 32, byte-address width of the fetch port.
- NOP_INSTR, 32'h00000013, value returned on any fault (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_start  in  1  pulse: request entry to LOAD mode.
- prog_we  in  1  write strobe, honoured only in LOAD.
- prog_addr  in  $clog2(DEPTH)  word index for the write.
- prog_data  in  WIDTH  word to write.
- prog_done  in  1  pulse: leave LOAD and enter RUN.
- loading  out  1  high while in LOAD.
- req_valid  in  1  fetch request valid.
- req_addr  in  ADDR_W  fetch byte address (the PC).
- req_ready  out  1  fetch request accepted this cycle.
- rsp_valid  out  1  response valid.
- rsp_instr  out  WIDTH  fetched instruction.
- rsp_fault  out  2  fault code: 00 ok, 01 misaligned, 10 out of range, 11 unprogrammed.
- rsp_ready  in  1  consumer accepts the response.

Behaviour:
Reset (async, rst_n low):
- state=LOAD; loading=1; req_ready=0.
- rsp_valid=0; rsp_instr=NOP_INSTR; rsp_fault=00.
- hwm_valid=0; hwm=0.
- Memory array is not reset; contents are undefined until written.

States:
- LOAD:
  - prog_we=1 writes mem[prog_addr]=prog_data at the clock edge.
  - If !hwm_valid or prog_addr>hwm: hwm<=prog_addr and hwm_valid<=1.
  - prog_done=1 moves to RUN next cycle. If prog_we is also 1 in that cycle, the write is still performed.
- RUN:
  - prog_we is ignored.
  - If prog_start=1 and no handshake is in flight: go to LOAD next cycle, with hwm_valid<=0.
  - "No handshake in flight" means rsp_valid=0, or rsp_valid&rsp_ready this cycle.
  - Otherwise prog_start is remembered in a pending flag and honoured once the response drains.
  - While the pending flag is set, req_ready=0.
- prog_start while already in LOAD: ignored. prog_done while in RUN: ignored.

Fetch handshake (RUN only):
- req_ready = (state==RUN) & !pending & (!rsp_valid | rsp_ready).
- Request accepted when req_valid & req_ready.
- On acceptance, the response is registered at the next edge: rsp_valid=1, plus rsp_instr and rsp_fault.
  - Latency is exactly 1 cycle.
  - Back-to-back accepts give 1 response per cycle.
- Response is held stable while rsp_valid & !rsp_ready.
- rsp_valid clears when rsp_ready=1 and no new accept occurs in the same cycle.
- Simultaneous consume and accept: rsp_valid stays 1 and the response is replaced with the new one.

Address decode (word index idx = req_addr >> 2, full ADDR_W-2 bits), in priority order:
1. req_addr[1:0] != 0 → fault 01.
2. idx >= DEPTH → fault 10. No wrap-around; upper address bits are compared, not truncated.
3. !hwm_valid or idx > hwm → fault 11.
4. Otherwise → fault 00, rsp_instr = mem[idx].

On any nonzero fault, rsp_instr = NOP_INSTR.

Reset mid-operation:
- Drops any response in flight. Returns to LOAD; the image must be reloaded.
- Stored words are not guaranteed to survive, and hwm is cleared.

Decomposition:
- Shared package (rv32i_pkg): fault-code constants FLT_OK/FLT_MISALIGN/FLT_RANGE/FLT_UNPROG; NOP_INSTR constant; state enum {LOAD, RUN}.
- One sub-module, imem_array: a 1-write, 1-read synchronous RAM of DEPTH×WIDTH with registered read and no reset. Kept separate so it can be swapped for an SRAM macro.
- Fault decode, hwm, FSM and response register live in the top module. The response register needs a capture-enable aligned to the RAM's registered read.

Test Plan:
1. Reset, then load words 0..20 with the existing 21-word program (00500113 … 00210063), pulse prog_done, fetch 0x00, 0x04, 0x50 back to back → responses 00500113, 00C00193, 00210063 on consecutive cycles, fault 00, loading=0.
2. After load to hwm=20: fetch 0x54 → NOP 00000013, fault 11. Fetch 0x100 (idx 64, DEPTH=64) → fault 10. Fetch 0x102 → fault 01 (misaligned takes priority).
3. Fetch 0x08 with rsp_ready held low for 3 cycles → rsp_valid=1 and rsp_instr=ff718393 stable; req_ready=0 throughout. One response delivered when rsp_ready rises.
4. Fetch in RUN, then assert prog_start while the response is stalled → stays RUN until consumed. Then LOAD, loading=1, req_ready=0. Any fetch before prog_done receives no response.
5. Assert prog_we in RUN with prog_addr=0, data=DEADBEEF → fetch 0x00 still returns 00500113.
6. Drive rst_n low mid-stream for 1 cycle, asynchronous to clk → rsp_valid drops immediately, state LOAD. After prog_done with no writes, fetch 0x00 → fault 11.
